// File: rtl/conv_window_gen.sv
// Sliding-window generator: buffers KH-1 image rows and emits every KH x KW window
// (stride 1, no padding) with its output position, over valid/ready streams.
module conv_window_gen #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMG_W  = 7,
  parameter int unsigned IMG_H  = 7,
  parameter int unsigned KH     = 3,
  parameter int unsigned KW     = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DATA_W-1:0]                          in_data,
  output logic                                       win_valid,
  input  logic                                       win_ready,
  output logic [KH*KW*DATA_W-1:0]                    win_data,
  output logic [(IMG_H > 1 ? $clog2(IMG_H) : 1)-1:0] win_row,
  output logic [(IMG_W > 1 ? $clog2(IMG_W) : 1)-1:0] win_col,
  output logic                                       frame_done
);

  localparam int unsigned RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  localparam int unsigned CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int unsigned LB = KH > 1 ? KH - 1 : 1;

  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(KH - 1);
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(KW - 1);

  typedef enum logic [1:0] {StFill, StRun, StLast} state_e;

  state_e            state_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [DATA_W-1:0] sr_q   [KH][KW];
  logic [DATA_W-1:0] sr_d   [KH][KW];
  logic [DATA_W-1:0] col_vec[KH];
  logic [DATA_W-1:0] lb_rd  [LB];
  logic [KH*KW*DATA_W-1:0] win_flat;

  logic pix_acc, win_acc, completes, last_pix;

  // Held low during reset so every output reads 0 while reset is asserted.
  assign in_ready   = reset & (~win_valid | win_ready);
  assign pix_acc    = in_valid & in_ready;
  assign win_acc    = win_valid & win_ready;
  assign completes  = (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);
  assign last_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign frame_done = win_acc && (state_q == StLast);

  // Line buffers: lb_q[0] holds the oldest buffered row; contents need no reset.
  if (KH > 1) begin : g_lb
    logic [DATA_W-1:0] lb_q [KH-1][IMG_W];

    always_ff @(posedge clk) begin
      if (pix_acc) begin
        for (int r = 0; r < int'(KH) - 2; r++) begin
          lb_q[r][col_q] <= lb_q[r+1][col_q];
        end
        lb_q[KH-2][col_q] <= in_data;
      end
    end

    always_comb begin
      for (int r = 0; r < int'(KH) - 1; r++) begin
        lb_rd[r] = lb_q[r][col_q];
      end
    end
  end else begin : g_no_lb
    assign lb_rd[0] = '0;
  end

  always_comb begin
    for (int r = 0; r < int'(KH) - 1; r++) begin
      col_vec[r] = lb_rd[r];
    end
    col_vec[KH-1] = in_data;
  end

  // Window shift register moves left one column; the new column enters at c = KW-1.
  always_comb begin
    for (int r = 0; r < int'(KH); r++) begin
      for (int c = 0; c < int'(KW) - 1; c++) begin
        sr_d[r][c] = sr_q[r][c+1];
      end
      sr_d[r][KW-1] = col_vec[r];
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < int'(KH); r++) begin
      for (int c = 0; c < int'(KW); c++) begin
        win_flat[(r*KW+c)*DATA_W +: DATA_W] = sr_d[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFill;
      col_q     <= '0;
      row_q     <= '0;
      sr_q      <= '{default: '0};
      win_valid <= 1'b0;
      win_data  <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (pix_acc) begin
      sr_q <= sr_d;
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
      if (completes) begin
        win_valid <= 1'b1;
        win_data  <= win_flat;
        win_row   <= row_q - ROW_FIRST_WIN;
        win_col   <= col_q - COL_FIRST_WIN;
      end else if (win_acc) begin
        win_valid <= 1'b0;
      end
      if (last_pix) begin
        state_q <= StLast;
      end else if (row_q >= ROW_FIRST_WIN) begin
        state_q <= StRun;
      end else begin
        state_q <= StFill;
      end
    end else if (win_acc) begin
      win_valid <= 1'b0;
      if (state_q == StLast) begin
        state_q <= StFill;
      end
    end
  end

endmodule
